// File: rtl/matmul_out_writer.sv
// matmul_out_writer: requantizes packed matmul accumulator beats (round-half-up,
// saturate, optional ReLU) and streams one packed word per beat into the output
// BRAM through a 2-entry skid FIFO, sequencing addresses 0..TOTAL_WORDS-1 per run.
module matmul_out_writer #(
    parameter int WIDTH_IN          = 32,
    parameter int FRAC_IN           = 16,
    parameter int WIDTH_OUT         = 16,
    parameter int FRAC_OUT          = 8,
    parameter int CHUNK_SIZE        = 4,
    parameter int NUM_CORES_A       = 2,
    parameter int NUM_CORES_B       = 2,
    parameter int A_OUTER_DIMENSION = 8,
    parameter int B_OUTER_DIMENSION = 8,
    localparam int LANES            = NUM_CORES_A * NUM_CORES_B * CHUNK_SIZE,
    localparam int TOTAL_WORDS      = (A_OUTER_DIMENSION * B_OUTER_DIMENSION) / LANES,
    localparam int ADDR_WIDTH       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         relu_en,
    output logic                         busy,
    output logic                         done,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH_IN-1:0]    in_data,
    output logic                         wr_en,
    input  logic                         wr_grant,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [LANES*WIDTH_OUT-1:0]   wr_data
);

    // The tiling must produce a whole number of beats per run.
    if (((A_OUTER_DIMENSION * B_OUTER_DIMENSION) % LANES) != 0) begin : g_bad_tiling
        $error("matmul_out_writer: result matrix size is not a multiple of LANES");
    end

    localparam int CNT_W   = ADDR_WIDTH + 1;
    localparam int EXT_W   = WIDTH_IN + 2;
    localparam int SHIFT   = FRAC_IN - FRAC_OUT;
    localparam int SHR     = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL     = (SHIFT < 0) ? -SHIFT : 0;
    localparam int RND_POS = (SHIFT > 1) ? (SHIFT - 1) : 0;

    // Half an output LSB expressed in input units; zero when no right shift happens.
    localparam logic signed [EXT_W-1:0] ROUND_C =
        (SHIFT > 0) ? ({{(EXT_W-1){1'b0}}, 1'b1} << RND_POS) : {EXT_W{1'b0}};
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (WIDTH_OUT - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

    localparam logic [CNT_W-1:0]      LAST_ACCEPT = CNT_W'(TOTAL_WORDS - 1);
    localparam logic [CNT_W-1:0]      ALL_ACCEPT  = CNT_W'(TOTAL_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(TOTAL_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Convert one accumulator lane to the output format.
    function automatic logic [WIDTH_OUT-1:0] requant_lane(
        input logic [WIDTH_IN-1:0] lane,
        input logic                relu
    );
        logic signed [EXT_W-1:0] ext_v;
        logic signed [EXT_W-1:0] scaled_v;
        logic [WIDTH_OUT-1:0]    sat_v;
        ext_v    = {{2{lane[WIDTH_IN-1]}}, lane};
        scaled_v = ((ext_v + ROUND_C) >>> SHR) <<< SHL;
        if (scaled_v > SAT_MAX) begin
            sat_v = SAT_MAX[WIDTH_OUT-1:0];
        end else if (scaled_v < SAT_MIN) begin
            sat_v = SAT_MIN[WIDTH_OUT-1:0];
        end else begin
            sat_v = scaled_v[WIDTH_OUT-1:0];
        end
        return (relu && sat_v[WIDTH_OUT-1]) ? {WIDTH_OUT{1'b0}} : sat_v;
    endfunction

    // Convert a whole packed beat, lane 0 at the LSBs.
    function automatic logic [LANES*WIDTH_OUT-1:0] requant_word(
        input logic [LANES*WIDTH_IN-1:0] word,
        input logic                      relu
    );
        logic [LANES*WIDTH_OUT-1:0] out_v;
        out_v = {(LANES*WIDTH_OUT){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            out_v[l*WIDTH_OUT +: WIDTH_OUT] = requant_lane(word[l*WIDTH_IN +: WIDTH_IN], relu);
        end
        return out_v;
    endfunction

    state_t                     state_r;
    logic                       relu_r;
    logic [CNT_W-1:0]           accept_cnt_r;
    logic [1:0]                 fifo_count_r;
    logic [LANES*WIDTH_OUT-1:0] fifo_head_r;
    logic [LANES*WIDTH_OUT-1:0] fifo_tail_r;
    logic [ADDR_WIDTH-1:0]      wr_addr_r;
    logic                       wr_en_r;
    logic                       in_ready_r;
    logic                       busy_r;
    logic                       done_r;

    logic                       accept_s;
    logic                       pop_s;
    logic                       start_s;
    state_t                     state_next_s;
    logic [CNT_W-1:0]           accept_next_s;
    logic [1:0]                 count_next_s;
    logic [ADDR_WIDTH-1:0]      addr_next_s;
    logic [LANES*WIDTH_OUT-1:0] conv_word_s;

    assign conv_word_s = requant_word(in_data, relu_r);

    // Handshakes and next-state values; outputs are registered from these.
    always_comb begin
        accept_s      = in_valid && in_ready_r;
        pop_s         = wr_en_r && wr_grant;
        start_s       = start && (state_r == ST_IDLE);
        state_next_s  = state_r;
        accept_next_s = accept_cnt_r;
        count_next_s  = fifo_count_r;
        addr_next_s   = wr_addr_r;

        case (state_r)
            ST_IDLE: begin
                if (start_s) state_next_s = ST_RUN;
                else         state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && (accept_cnt_r == LAST_ACCEPT)) state_next_s = ST_DRAIN;
                else                                           state_next_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (pop_s && (wr_addr_r == LAST_ADDR)) state_next_s = ST_DONE;
                else                                   state_next_s = ST_DRAIN;
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (start_s) begin
            accept_next_s = {CNT_W{1'b0}};
        end else if (accept_s) begin
            accept_next_s = accept_cnt_r + CNT_W'(1);
        end else begin
            accept_next_s = accept_cnt_r;
        end

        case ({accept_s, pop_s})
            2'b10:   count_next_s = fifo_count_r + 2'd1;
            2'b01:   count_next_s = fifo_count_r - 2'd1;
            default: count_next_s = fifo_count_r;
        endcase

        // The address stops at the last word so it never wraps inside a run.
        if (start_s) begin
            addr_next_s = {ADDR_WIDTH{1'b0}};
        end else if (pop_s && (wr_addr_r != LAST_ADDR)) begin
            addr_next_s = wr_addr_r + ADDR_WIDTH'(1);
        end else begin
            addr_next_s = wr_addr_r;
        end
    end

    // Control FSM, counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            relu_r       <= 1'b0;
            accept_cnt_r <= {CNT_W{1'b0}};
            fifo_count_r <= 2'd0;
            wr_addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_en_r      <= 1'b0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            relu_r       <= start_s ? relu_en : relu_r;
            accept_cnt_r <= accept_next_s;
            fifo_count_r <= count_next_s;
            wr_addr_r    <= addr_next_s;
            wr_en_r      <= (count_next_s != 2'd0);
            in_ready_r   <= (state_next_s == ST_RUN) && (count_next_s < 2'd2) &&
                            (accept_next_s < ALL_ACCEPT);
            busy_r       <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
            done_r       <= (state_next_s == ST_DONE);
        end
    end

    // Skid FIFO storage: head is always the word presented to the BRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_head_r <= {(LANES*WIDTH_OUT){1'b0}};
            fifo_tail_r <= {(LANES*WIDTH_OUT){1'b0}};
        end else begin
            if (pop_s && (fifo_count_r == 2'd2)) begin
                fifo_head_r <= fifo_tail_r;
            end else if (accept_s && ((fifo_count_r == 2'd0) || pop_s)) begin
                fifo_head_r <= conv_word_s;
            end else begin
                fifo_head_r <= fifo_head_r;
            end

            if (accept_s && !pop_s && (fifo_count_r == 2'd1)) begin
                fifo_tail_r <= conv_word_s;
            end else begin
                fifo_tail_r <= fifo_tail_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign in_ready = in_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = fifo_head_r;

endmodule

// File: tb/tb_matmul_out_writer.sv
// Self-checking bench for matmul_out_writer with default parameters
// (16 lanes, 32-bit Q16 in, 16-bit Q8 out, 4 words per run).
module tb_matmul_out_writer;

    localparam int WIDTH_IN   = 32;
    localparam int WIDTH_OUT  = 16;
    localparam int LANES      = 16;
    localparam int ADDR_WIDTH = 2;
    localparam int DW_IN      = LANES * WIDTH_IN;
    localparam int DW_OUT     = LANES * WIDTH_OUT;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              relu_en  = 1'b0;
    logic              in_valid = 1'b0;
    logic              wr_grant = 1'b0;
    logic [DW_IN-1:0]  in_data  = '0;
    logic              busy, done, in_ready, wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DW_OUT-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    matmul_out_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .relu_en  (relu_en),
        .busy     (busy),
        .done     (done),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_grant (wr_grant),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // ---------------- observation (records only, no judging) ----------------
    int cyc = 0;
    logic [ADDR_WIDTH-1:0] got_addr[$];
    logic [DW_OUT-1:0]     got_data[$];
    int                    got_cyc[$];
    int                    acc_cyc[$];
    int                    done_cnt  = 0;
    int                    done_cyc  = 0;
    logic                  done_busy = 1'b0;
    int                    hold_viol = 0;
    logic                  stall_q   = 1'b0;
    logic [ADDR_WIDTH-1:0] hold_addr = '0;
    logic [DW_OUT-1:0]     hold_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en && wr_grant) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_busy <= busy;
        end
        if (rst_n && stall_q && (wr_en !== 1'b1 || wr_addr !== hold_addr || wr_data !== hold_data))
            hold_viol <= hold_viol + 1;
        stall_q   <= rst_n && wr_en && !wr_grant;
        hold_addr <= wr_addr;
        hold_data <= wr_data;
    end

    // ---------------- reference model ----------------
    // value * 2^-16 rounded half-up to a multiple of 2^-8, saturated to int16
    function automatic logic [WIDTH_OUT-1:0] ref_lane(input logic [WIDTH_IN-1:0] raw, input bit relu);
        longint v;
        longint q;
        real    r;
        v = longint'($signed(raw));
        r = $floor(real'(v) / 256.0 + 0.5);
        q = longint'(r);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return q[WIDTH_OUT-1:0];
    endfunction

    function automatic logic [DW_OUT-1:0] ref_word(input logic [DW_IN-1:0] w, input bit relu);
        logic [DW_OUT-1:0] o;
        o = '0;
        for (int l = 0; l < LANES; l++)
            o[l*WIDTH_OUT +: WIDTH_OUT] = ref_lane(w[l*WIDTH_IN +: WIDTH_IN], relu);
        return o;
    endfunction

    function automatic logic [DW_IN-1:0] rand_beat();
        logic [DW_IN-1:0] b;
        logic [31:0]      x;
        b = '0;
        for (int l = 0; l < LANES; l++) begin
            x = $urandom();
            if ($urandom_range(0, 2) != 0) x = {{8{x[23]}}, x[23:0]};
            b[l*WIDTH_IN +: WIDTH_IN] = x;
        end
        return b;
    endfunction

    // ---------------- stimulus helpers (no comparisons) ----------------
    logic [DW_IN-1:0] tx_beats[$];

    task automatic start_run(input bit relu);
        start   = 1'b1;
        relu_en = relu;
        @(posedge clk); #1;
        start   = 1'b0;
        relu_en = ~relu;
    endtask

    // Offer tx_beats from index 'first' until 'want' writes have been recorded.
    task automatic drive(input int first, input int want, input int max_cyc);
        int i = first;
        int k = 0;
        wr_grant = 1'b1;
        while (got_data.size() < want && k < max_cyc) begin
            if (i < tx_beats.size()) begin
                in_valid = 1'b1;
                in_data  = tx_beats[i];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int ab;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, in_ready, wr_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, in_ready, wr_en});
        end
        checks++;
        if (wr_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", wr_addr); end
        checks++;
        if (wr_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", wr_data); end
        rst_n    = 1'b1;
        ab       = acc_cyc.size();
        in_valid = 1'b1;
        in_data  = rand_beat();
        wr_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (acc_cyc.size() != ab) begin
            errors++; $display("FAIL idle_accept: got %0d accepts expected 0", acc_cyc.size() - ab);
        end
    endtask

    task automatic test_single_beat();
        int wb = got_data.size();
        int ab = acc_cyc.size();
        logic [DW_IN-1:0] b0;
        for (int l = 0; l < LANES; l++) b0[l*WIDTH_IN +: WIDTH_IN] = 32'h0001_8000;
        tx_beats.delete();
        tx_beats.push_back(b0);
        for (int j = 1; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
        drive(0, wb + 4, 100);
        checks++;
        if (got_data.size() != wb + 4) begin
            errors++; $display("FAIL single_count: got %0d writes expected 4", got_data.size() - wb);
        end else begin
            checks++;
            if (got_addr[wb] !== 2'd0) begin errors++; $display("FAIL single_addr: got %0d expected 0", got_addr[wb]); end
            checks++;
            if (got_data[wb] !== {LANES{16'h0180}}) begin
                errors++; $display("FAIL single_data: got %h expected all lanes 0180", got_data[wb]);
            end
            checks++;
            if (got_cyc[wb] != acc_cyc[ab] + 1) begin
                errors++; $display("FAIL single_latency: got %0d cycles expected 1", got_cyc[wb] - acc_cyc[ab]);
            end
            for (int j = 1; j < 4; j++) begin
                checks++;
                if (got_data[wb+j] !== ref_word(tx_beats[j], 1'b0)) begin
                    errors++; $display("FAIL single_rand%0d: got %h expected %h", j, got_data[wb+j], ref_word(tx_beats[j], 1'b0));
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_rounding();
        logic [31:0] pats[5];
        logic [15:0] exps[5];
        int wb = got_data.size();
        logic [DW_IN-1:0] b0;
        pats = '{32'h0000_0080, 32'h0000_007F, 32'h7FFF_0000, 32'h8000_0000, 32'hFFFF_0000};
        exps = '{16'h0001, 16'h0000, 16'h7FFF, 16'h8000, 16'hFF00};
        for (int l = 0; l < LANES; l++) b0[l*WIDTH_IN +: WIDTH_IN] = pats[l % 5];
        tx_beats.delete();
        tx_beats.push_back(b0);
        for (int j = 1; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b0);
        drive(0, wb + 4, 100);
        checks++;
        if (got_data.size() != wb + 4) begin
            errors++; $display("FAIL round_count: got %0d writes expected 4", got_data.size() - wb);
        end else begin
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (got_data[wb][l*WIDTH_OUT +: WIDTH_OUT] !== exps[l % 5]) begin
                    errors++; $display("FAIL round_lane%0d: got %h expected %h", l, got_data[wb][l*WIDTH_OUT +: WIDTH_OUT], exps[l % 5]);
                end
            end
            for (int j = 1; j < 4; j++) begin
                checks++;
                if (got_data[wb+j] !== ref_word(tx_beats[j], 1'b0)) begin
                    errors++; $display("FAIL round_rand%0d: got %h expected %h", j, got_data[wb+j], ref_word(tx_beats[j], 1'b0));
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_relu();
        int wb = got_data.size();
        logic [DW_IN-1:0] b0;
        for (int l = 0; l < LANES; l++)
            b0[l*WIDTH_IN +: WIDTH_IN] = (l % 2 == 0) ? 32'hFFFF_0000 : 32'h0002_0000;
        tx_beats.delete();
        tx_beats.push_back(b0);
        for (int j = 1; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b1);
        drive(0, wb + 4, 100);
        checks++;
        if (got_data.size() != wb + 4) begin
            errors++; $display("FAIL relu_count: got %0d writes expected 4", got_data.size() - wb);
        end else begin
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if (got_data[wb][l*WIDTH_OUT +: WIDTH_OUT] !== ((l % 2 == 0) ? 16'h0000 : 16'h0200)) begin
                    errors++; $display("FAIL relu_lane%0d: got %h", l, got_data[wb][l*WIDTH_OUT +: WIDTH_OUT]);
                end
            end
            for (int j = 1; j < 4; j++) begin
                checks++;
                if (got_data[wb+j] !== ref_word(tx_beats[j], 1'b1)) begin
                    errors++; $display("FAIL relu_rand%0d: got %h expected %h", j, got_data[wb+j], ref_word(tx_beats[j], 1'b1));
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int wb = got_data.size();
        int ab = acc_cyc.size();
        int dc = done_cnt;
        tx_beats.delete();
        for (int j = 0; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b0);
        drive(0, wb + 4, 100);
        in_valid = 1'b1;
        in_data  = rand_beat();
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (got_data.size() != wb + 4) begin
            errors++; $display("FAIL b2b_count: got %0d writes expected 4", got_data.size() - wb);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (got_addr[wb+j] !== 2'(j) || got_cyc[wb+j] != got_cyc[wb] + j) begin
                    errors++; $display("FAIL b2b_seq%0d: got addr %0d cycle +%0d expected addr %0d cycle +%0d",
                                       j, got_addr[wb+j], got_cyc[wb+j] - got_cyc[wb], j, j);
                end
                checks++;
                if (got_data[wb+j] !== ref_word(tx_beats[j], 1'b0)) begin
                    errors++; $display("FAIL b2b_data%0d: got %h expected %h", j, got_data[wb+j], ref_word(tx_beats[j], 1'b0));
                end
            end
            checks++;
            if (done_cnt != dc + 1 || done_cyc != got_cyc[wb+3] + 1) begin
                errors++; $display("FAIL b2b_done: got %0d pulses at +%0d expected 1 pulse at +1",
                                   done_cnt - dc, done_cyc - got_cyc[wb+3]);
            end
        end
        checks++;
        if (done_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done: got %b expected 0", done_busy); end
        checks++;
        if (acc_cyc.size() != ab + 4) begin
            errors++; $display("FAIL b2b_extra_beat: got %0d accepts expected 4", acc_cyc.size() - ab);
        end
    endtask

    task automatic test_backpressure();
        int wb = got_data.size();
        int ab = acc_cyc.size();
        int hv = hold_viol;
        int i  = 0;
        tx_beats.delete();
        for (int j = 0; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b0);
        wr_grant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = tx_beats[i];
            start    = (k == 3);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (acc_cyc.size() != ab + 2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_accepts: got %0d accepts in_ready %b expected 2 and 0", acc_cyc.size() - ab, in_ready);
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd0) begin
            errors++; $display("FAIL bp_stall_head: got wr_en %b addr %0d expected 1 and 0", wr_en, wr_addr);
        end
        checks++;
        if (wr_data !== ref_word(tx_beats[0], 1'b0)) begin
            errors++; $display("FAIL bp_stall_data: got %h expected %h", wr_data, ref_word(tx_beats[0], 1'b0));
        end
        drive(i, wb + 4, 100);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_data.size() != wb + 4 || acc_cyc.size() != ab + 4) begin
            errors++; $display("FAIL bp_count: got %0d writes %0d accepts expected 4 and 4", got_data.size() - wb, acc_cyc.size() - ab);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (got_addr[wb+j] !== 2'(j) || got_data[wb+j] !== ref_word(tx_beats[j], 1'b0)) begin
                    errors++; $display("FAIL bp_word%0d: got addr %0d data %h expected addr %0d data %h",
                                       j, got_addr[wb+j], got_data[wb+j], j, ref_word(tx_beats[j], 1'b0));
                end
            end
        end
        checks++;
        if (hold_viol != hv) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_viol - hv); end
    endtask

    task automatic test_reset_midrun();
        int wb = got_data.size();
        int dc;
        tx_beats.delete();
        for (int j = 0; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b0);
        drive(0, wb + 2, 100);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready, wr_en} !== 4'b0000 || wr_addr !== 2'd0 || wr_data !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs: got flags %b addr %0d data %h expected all zero",
                               {busy, done, in_ready, wr_en}, wr_addr, wr_data);
        end
        dc = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != dc) begin errors++; $display("FAIL midrun_no_done: got %0d pulses expected 0", done_cnt - dc); end
        wb = got_data.size();
        tx_beats.delete();
        for (int j = 0; j < 4; j++) tx_beats.push_back(rand_beat());
        start_run(1'b0);
        drive(0, wb + 4, 100);
        checks++;
        if (got_data.size() != wb + 4) begin
            errors++; $display("FAIL midrun_rerun_count: got %0d writes expected 4", got_data.size() - wb);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (got_addr[wb+j] !== 2'(j) || got_data[wb+j] !== ref_word(tx_beats[j], 1'b0)) begin
                    errors++; $display("FAIL midrun_rerun%0d: got addr %0d data %h expected addr %0d data %h",
                                       j, got_addr[wb+j], got_data[wb+j], j, ref_word(tx_beats[j], 1'b0));
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_rounding();
        test_relu();
        test_back_to_back();
        test_backpressure();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_out_writer.md
Name: matmul_out_writer

Overview:
Downstream stage of the linear-projection matmul array. It consumes the packed per-core output chunks, requantizes each lane from accumulator format to output format with round-half-up, saturation and optional ReLU, and writes one packed word per accepted beat into the output BRAM. Address sequencing and done signalling follow the matmul tiling parameters. A 2-entry skid FIFO decouples matmul handshake from BRAM write grant.

Parameters:
WIDTH_IN, 32, signed accumulator lane width from matmul cores
FRAC_IN, 16, fractional bits of input lanes
WIDTH_OUT, 16, signed output lane width
FRAC_OUT, 8, fractional bits of output lanes
CHUNK_SIZE, 4, lanes per core per beat (BLOCK_SIZE*BLOCK_SIZE)
NUM_CORES_A, 2, core rows
NUM_CORES_B, 2, core columns
A_OUTER_DIMENSION, 8, rows of result matrix
B_OUTER_DIMENSION, 8, columns of result matrix
LANES, NUM_CORES_A*NUM_CORES_B*CHUNK_SIZE, derived lanes per beat (16)
TOTAL_WORDS, (A_OUTER_DIMENSION*B_OUTER_DIMENSION)/LANES, derived beats per run (4); must divide exactly, elaboration error otherwise
ADDR_WIDTH, max(1,$clog2(TOTAL_WORDS)), derived

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse starting a run; ignored while busy
relu_en  in  1  sampled at start; 1 clamps negative outputs to 0
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last BRAM write granted
in_valid  in  1  matmul output beat valid
in_ready  out  1  block accepts beat this cycle
in_data  in  LANES*WIDTH_IN  packed lanes, lane 0 at LSBs
wr_en  out  1  BRAM write request
wr_grant  in  1  BRAM accepts write this cycle
wr_addr  out  ADDR_WIDTH  word address
wr_data  out  LANES*WIDTH_OUT  packed requantized lanes, lane 0 at LSBs

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0; FIFO empty; counters 0. Reset mid-run abandons the run; no done.
- FSM: IDLE -start-> RUN (latch relu_en, clear accept/write counters). RUN -accepted count reaches TOTAL_WORDS-> DRAIN. DRAIN -last write granted-> DONE. DONE -> IDLE next cycle, done=1 for exactly that cycle.
- in_ready = (state==RUN) && (fifo_count<2) && (accept_cnt<TOTAL_WORDS). Beat accepted when in_valid && in_ready.
- Requant per lane, registered on FIFO write: s=FRAC_IN-FRAC_OUT. s>0: add 2^(s-1), arithmetic shift right s. s=0: pass. s<0: shift left -s. Compute at width WIDTH_IN+2 to avoid overflow. Saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]. Then, if relu latched, negative -> 0.
- FIFO: 2 entries holding converted words. wr_en = FIFO non-empty; wr_data = head; pops on wr_en && wr_grant. Simultaneous push and pop with count 2 not possible (in_ready=0); with count 1 allowed, count stays 1.
- Latency: beat accepted at cycle t with FIFO empty -> wr_en=1 with that data at t+1. Full throughput (1 beat/cycle) with wr_grant held 1.
- wr_en, wr_addr, wr_data stable while wr_en && !wr_grant.
- wr_addr starts 0, increments on each grant, 0..TOTAL_WORDS-1; reset to 0 on start. No wrap within a run.
- start during RUN/DRAIN/DONE ignored. start in same cycle as done's DONE state ignored; next start accepted from IDLE.
- in_valid outside RUN ignored (no acceptance).

Test Plan:
- Single beat, all lanes 0x0001_8000, relu_en=0, wr_grant=1 -> wr_en at t+1, every lane 0x0180, wr_addr=0.
- Rounding/saturation: lanes 0x0000_0080 -> 0x0001; 0x0000_007F -> 0x0000; 0x7FFF_0000 -> 0x7FFF; 0x8000_0000 -> 0x8000; 0xFFFF_0000 -> 0xFF00.
- ReLU: start with relu_en=1, lane 0xFFFF_0000 -> 0x0000; lane 0x0002_0000 -> 0x0200.
- Full run, 4 back-to-back beats, wr_grant=1 -> addresses 0,1,2,3 consecutive cycles, done pulse one cycle after last grant, busy falls with done, 5th in_valid not accepted.
- Backpressure: wr_grant=0 for 5 cycles -> in_ready drops after 2 accepts, wr_en/addr/data held; grant resumes -> all 4 words written in order, no loss or duplicate.
- Reset mid-run after 2 writes -> all outputs 0 immediately, no done; new start rewrites from addr 0.
